// File: rtl/status_handshake_tx_if.sv
// rtl/status_handshake_tx_if.sv - status link bundle between monitor, transmitter and filter core
//
// Purpose: groups the status input, the four-phase data/req/ack link and the
// transmitter status flags so they travel as one port.
// Ports (signals):
//   status_in, status_valid : new status code from the monitor
//   data, req, ack          : four-phase link to the filter core
//   busy, tx_done, tx_error : transmitter progress / result pulses
//   fault, last_sent        : sticky failure flag, last delivered code
// Modports:
//   master : the transmitter side
//   slave  : the environment (monitor + filter core) side
interface status_handshake_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] status_in;
    logic              status_valid;
    logic [DATA_W-1:0] data;
    logic              req;
    logic              ack;
    logic              busy;
    logic              tx_done;
    logic              tx_error;
    logic              fault;
    logic [DATA_W-1:0] last_sent;

    modport master (
        input  status_in,
        input  status_valid,
        input  ack,
        output data,
        output req,
        output busy,
        output tx_done,
        output tx_error,
        output fault,
        output last_sent
    );

    modport slave (
        output status_in,
        output status_valid,
        output ack,
        input  data,
        input  req,
        input  busy,
        input  tx_done,
        input  tx_error,
        input  fault,
        input  last_sent
    );
endinterface

// File: rtl/status_handshake_tx.sv
// rtl/status_handshake_tx.sv - four-phase status link transmitter with change filter, timeout, retry and refresh
//
// Purpose: forwards changed water-quality status codes to the filter core over
// a data/req/ack four-phase handshake. Data is frozen while req is high, a
// missing or stuck ack aborts the attempt after ACK_TIMEOUT_CYCLES, failed
// attempts are retried after a backoff, and the last delivered code can be
// re-sent periodically.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : status_handshake_tx_if.master (status_in/status_valid in,
//           data/req out, ack in, busy/tx_done/tx_error/fault/last_sent out)
module status_handshake_tx #(
    parameter int DATA_W             = 4,
    parameter int ACK_TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES        = 3,
    parameter int BACKOFF_CYCLES     = 100,
    parameter int REFRESH_CYCLES     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    status_handshake_tx_if.master bus
);

    // Limits are clamped to at least 1 so every comparison stays meaningful.
    localparam int ACK_LIM = (ACK_TIMEOUT_CYCLES > 0) ? ACK_TIMEOUT_CYCLES : 1;
    localparam int BO_LIM  = (BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES : 1;
    localparam int REF_LIM = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES : 1;
    localparam int TMAX_AB = (ACK_LIM > BO_LIM) ? ACK_LIM : BO_LIM;
    localparam int TMAX    = (TMAX_AB > REF_LIM) ? TMAX_AB : REF_LIM;
    localparam int TW      = $clog2(TMAX + 2);
    localparam int RW      = $clog2(MAX_RETRIES + 2);

    localparam logic [TW:0]   ACK_LIM_V = (TW+1)'(ACK_LIM);
    localparam logic [TW:0]   BO_LIM_V  = (TW+1)'(BO_LIM);
    localparam logic [TW:0]   REF_LIM_V = (TW+1)'(REF_LIM);
    localparam logic [RW-1:0] MAX_R_V   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK_HI,
        WAIT_ACK_LO,
        BACKOFF,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] pend_code_q, pend_code_d;
    logic [DATA_W-1:0] last_sent_q, last_sent_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [TW-1:0]     refresh_q, refresh_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              tx_error_q, tx_error_d;
    logic              fault_q, fault_d;

    logic              new_code;
    logic              attempt_failed;
    logic [TW:0]       timer_inc;
    logic [TW:0]       refresh_inc;
    logic [TW-1:0]     timer_sat;
    logic [TW-1:0]     refresh_sat;

    // timer_inc is the number of cycles spent in the current phase including
    // this one; the saturating copies never wrap.
    assign timer_inc   = {1'b0, timer_q} + 1'b1;
    assign refresh_inc = {1'b0, refresh_q} + 1'b1;
    assign timer_sat   = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign refresh_sat = (&refresh_q) ? refresh_q : refresh_q + 1'b1;

    // The change filter compares against the last delivered code, not the
    // code in flight.
    assign new_code = bus.status_valid && (bus.status_in != last_sent_q);

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        req_d          = req_q;
        pending_d      = pending_q;
        pend_code_d    = pend_code_q;
        last_sent_d    = last_sent_q;
        timer_d        = timer_sat;
        refresh_d      = '0;
        retry_d        = retry_q;
        tx_error_d     = 1'b0;
        fault_d        = fault_q;
        attempt_failed = 1'b0;

        // Pending register: latest code wins; a repeat of last_sent cancels.
        if (bus.status_valid) begin
            if (new_code) begin
                pending_d   = 1'b1;
                pend_code_d = bus.status_in;
            end else begin
                pending_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                refresh_d = refresh_sat;
                if (bus.status_valid) begin
                    if (new_code) begin
                        data_d    = bus.status_in;
                        req_d     = 1'b1;
                        timer_d   = '0;
                        pending_d = 1'b0;
                        refresh_d = '0;
                        state_d   = WAIT_ACK_HI;
                    end
                end else if (pending_q) begin
                    data_d    = pend_code_q;
                    req_d     = 1'b1;
                    timer_d   = '0;
                    pending_d = 1'b0;
                    refresh_d = '0;
                    state_d   = WAIT_ACK_HI;
                end else if ((REFRESH_CYCLES > 0) && (refresh_inc >= REF_LIM_V)) begin
                    data_d    = last_sent_q;
                    req_d     = 1'b1;
                    timer_d   = '0;
                    refresh_d = '0;
                    state_d   = WAIT_ACK_HI;
                end
            end

            WAIT_ACK_HI: begin
                // ack wins over a timeout in the same cycle.
                if (bus.ack) begin
                    req_d   = 1'b0;
                    timer_d = '0;
                    state_d = WAIT_ACK_LO;
                end else if (timer_inc >= ACK_LIM_V) begin
                    attempt_failed = 1'b1;
                end
            end

            WAIT_ACK_LO: begin
                if (!bus.ack) begin
                    last_sent_d = data_q;
                    state_d     = DONE;
                    // A pending copy of the code just delivered is now redundant.
                    if (pending_d && (pend_code_d == data_q)) begin
                        pending_d = 1'b0;
                    end
                end else if (timer_inc >= ACK_LIM_V) begin
                    attempt_failed = 1'b1;
                end
            end

            BACKOFF: begin
                // Never raise req again while the receiver still holds ack.
                if ((timer_inc >= BO_LIM_V) && !bus.ack) begin
                    req_d   = 1'b1;
                    timer_d = '0;
                    state_d = WAIT_ACK_HI;
                    if (pending_d) begin
                        data_d    = pend_code_d;
                        pending_d = 1'b0;
                    end
                end
            end

            DONE: begin
                fault_d = 1'b0;
                retry_d = '0;
                state_d = IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (attempt_failed) begin
            req_d   = 1'b0;
            timer_d = '0;
            if (retry_q < MAX_R_V) begin
                retry_d = retry_q + 1'b1;
                state_d = BACKOFF;
            end else begin
                tx_error_d = 1'b1;
                fault_d    = 1'b1;
                retry_d    = '0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            req_q       <= 1'b0;
            pending_q   <= 1'b0;
            pend_code_q <= '0;
            last_sent_q <= '0;
            timer_q     <= '0;
            refresh_q   <= '0;
            retry_q     <= '0;
            tx_error_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            req_q       <= req_d;
            pending_q   <= pending_d;
            pend_code_q <= pend_code_d;
            last_sent_q <= last_sent_d;
            timer_q     <= timer_d;
            refresh_q   <= refresh_d;
            retry_q     <= retry_d;
            tx_error_q  <= tx_error_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.req       = req_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tx_done   = (state_q == DONE);
    assign bus.tx_error  = tx_error_q;
    assign bus.fault     = fault_q;
    assign bus.last_sent = last_sent_q;

endmodule
